// File: rtl/oai211_bist.sv
// Built-in self-test sequencer for a bank of CH external OAI211 cells.
// Walks all 16 input vectors, checks every ZN against ~((A1|A2)&B&C), and reports results.
module oai211_bist #(
  parameter int CH     = 4,
  parameter int SETTLE = 2,
  parameter int ERRW   = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  output logic [CH-1:0]   A1,
  output logic [CH-1:0]   A2,
  output logic [CH-1:0]   B,
  output logic [CH-1:0]   C,
  input  logic [CH-1:0]   ZN,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [ERRW-1:0] ERR_CNT,
  output logic [CH-1:0]   FAIL_MASK
);

  // Accumulator is wide enough that neither the running count nor one popcount can wrap it.
  localparam int SW = ((ERRW > CH) ? ERRW : CH) + 1;
  localparam logic [SW-1:0] ERR_MAX = {{(SW-ERRW){1'b0}}, {ERRW{1'b1}}};

  typedef enum logic [2:0] {stIdle, stApply, stWait, stCheck, stDone} state_t;

  state_t          state, stateNext;
  logic [3:0]      vec, vecNext;
  logic [3:0]      waitCnt, waitNext;
  logic [3:0]      chanVec [CH];
  logic [CH-1:0]   a1Next, a2Next, bNext, cNext;
  logic [CH-1:0]   golden, mismatch, maskNext;
  logic [CH-1:0]   popCnt;
  logic [SW-1:0]   errSum;
  logic [ERRW-1:0] errNext;
  logic            busyNext, doneNext, passNext;

  // Golden response is taken from the held stimulus registers, so it always matches what the cells see.
  always_comb begin
    golden   = ~((A1 | A2) & B & C);
    mismatch = ZN ^ golden;
    popCnt   = '0;
    for (int k = 0; k < CH; k++) begin
      popCnt = popCnt + CH'(mismatch[k]);
      chanVec[k] = vec + 4'(k);
    end
    errSum = SW'(ERR_CNT) + SW'(popCnt);
  end

  always_comb begin
    stateNext = state;
    vecNext   = vec;
    waitNext  = waitCnt;
    a1Next    = A1;
    a2Next    = A2;
    bNext     = B;
    cNext     = C;
    errNext   = ERR_CNT;
    maskNext  = FAIL_MASK;
    case (state)
      stIdle, stDone: begin
        if (START) begin
          stateNext = stApply;
          vecNext   = '0;
          errNext   = '0;
          maskNext  = '0;
        end
      end
      stApply: begin
        for (int k = 0; k < CH; k++) begin
          a1Next[k] = chanVec[k][0];
          a2Next[k] = chanVec[k][1];
          bNext[k]  = chanVec[k][2];
          cNext[k]  = chanVec[k][3];
        end
        if (SETTLE == 0) begin
          stateNext = stCheck;
        end else begin
          stateNext = stWait;
          waitNext  = 4'(SETTLE - 1);
        end
      end
      stWait: begin
        if (waitCnt == '0) begin
          stateNext = stCheck;
        end else begin
          waitNext = waitCnt - 4'd1;
        end
      end
      stCheck: begin
        maskNext = FAIL_MASK | mismatch;
        errNext  = (errSum > ERR_MAX) ? ERR_MAX[ERRW-1:0] : errSum[ERRW-1:0];
        if (vec == 4'd15) begin
          stateNext = stDone;
          a1Next    = '0;
          a2Next    = '0;
          bNext     = '0;
          cNext     = '0;
        end else begin
          stateNext = stApply;
          vecNext   = vec + 4'd1;
        end
      end
      default: stateNext = stIdle;
    endcase
    busyNext = (stateNext == stApply) || (stateNext == stWait) || (stateNext == stCheck);
    doneNext = (stateNext == stDone);
    passNext = doneNext && (errNext == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= stIdle;
      vec       <= '0;
      waitCnt   <= '0;
      A1        <= '0;
      A2        <= '0;
      B         <= '0;
      C         <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      ERR_CNT   <= '0;
      FAIL_MASK <= '0;
    end else begin
      state     <= stateNext;
      vec       <= vecNext;
      waitCnt   <= waitNext;
      A1        <= a1Next;
      A2        <= a2Next;
      B         <= bNext;
      C         <= cNext;
      BUSY      <= busyNext;
      DONE      <= doneNext;
      PASS      <= passNext;
      ERR_CNT   <= errNext;
      FAIL_MASK <= maskNext;
    end
  end

endmodule

// File: tb/tb_oai211_bist.sv
// Scoreboard bench for oai211_bist: two instances (SETTLE=2/ERRW=8 and SETTLE=0/ERRW=2) with
// loopback cells whose faults come from per-channel flip tables indexed by the applied vector.
module tb_oai211_bist;

  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start [2];
  logic [CH-1:0] a1 [2], a2 [2], b [2], c [2], zn [2], mask [2];
  logic          busy [2], done [2], pass [2];
  logic [7:0]    err0;
  logic [1:0]    err1;
  logic [15:0]   flip [2][CH];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0c [2];
  bit active [2];
  bit prevDone [2];
  int period [2] = '{4, 2};
  int errMax [2] = '{255, 3};

  typedef struct {
    int            err;
    logic [CH-1:0] mask;
    logic          pass;
  } exp_t;
  exp_t sbq [2][$];

  oai211_bist #(.CH(CH), .SETTLE(2), .ERRW(8)) u0 (
    .CLK(clk), .RST(rst), .START(start[0]),
    .A1(a1[0]), .A2(a2[0]), .B(b[0]), .C(c[0]), .ZN(zn[0]),
    .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]),
    .ERR_CNT(err0), .FAIL_MASK(mask[0])
  );

  oai211_bist #(.CH(CH), .SETTLE(0), .ERRW(2)) u1 (
    .CLK(clk), .RST(rst), .START(start[1]),
    .A1(a1[1]), .A2(a2[1]), .B(b[1]), .C(c[1]), .ZN(zn[1]),
    .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]),
    .ERR_CNT(err1), .FAIL_MASK(mask[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // A cell answers with the true OAI211 value, flipped wherever its fault table says so.
  function automatic logic cellOut(logic [3:0] w, logic [15:0] f);
    return (~((w[0] | w[1]) & w[2] & w[3])) ^ f[w];
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < CH; k++) begin
        zn[d][k] = cellOut({c[d][k], b[d][k], a2[d][k], a1[d][k]}, flip[d][k]);
      end
    end
  end

  function automatic logic [31:0] errOf(int d);
    return (d == 0) ? 32'(err0) : 32'(err1);
  endfunction

  function automatic logic [31:0] stimOf(int d);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < CH; k++) s[4*k +: 4] = {c[d][k], b[d][k], a2[d][k], a1[d][k]};
    return s;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic checkAllZero(int d, string tag);
    checkOutput({tag, " busy"}, 32'(busy[d]), 32'd0);
    checkOutput({tag, " done"}, 32'(done[d]), 32'd0);
    checkOutput({tag, " pass"}, 32'(pass[d]), 32'd0);
    checkOutput({tag, " err"}, errOf(d), 32'd0);
    checkOutput({tag, " mask"}, 32'(mask[d]), 32'd0);
    checkOutput({tag, " stim"}, stimOf(d), 32'd0);
  endtask

  // Every channel sees every one of the 16 vectors once, so a run's outcome is just the flip counts.
  task automatic applyStimulus(int d);
    exp_t e;
    int   raw;
    raw    = 0;
    e.mask = '0;
    for (int k = 0; k < CH; k++) begin
      for (int w = 0; w < 16; w++) begin
        if (flip[d][k][w]) begin
          raw++;
          e.mask[k] = 1'b1;
        end
      end
    end
    e.err  = (raw > errMax[d]) ? errMax[d] : raw;
    e.pass = (e.err == 0);
    sbq[d].push_back(e);
    start[d]  = 1'b1;
    t0c[d]    = cyc + 1;
    active[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic waitDone(int d);
    int guard;
    guard = 0;
    while (active[d] && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (active[d]) begin
      checkOutput("run timeout", 32'd1, 32'd0);
      active[d] = 1'b0;
    end
  endtask

  task automatic setFlips(int d, int mode);
    for (int k = 0; k < CH; k++) begin
      case (mode)
        0:       flip[d][k] = 16'h0000;
        1:       flip[d][k] = 16'hFFFF;
        default: flip[d][k] = 16'($urandom & $urandom);
      endcase
    end
  endtask

  // Monitor: per-cycle BUSY/stimulus timing while a run is open, and scoreboard pop on each DONE rise.
  always @(posedge clk) begin
    #2;
    for (int d = 0; d < 2; d++) begin
      int   n;
      int   p;
      int   v;
      exp_t e;
      if (active[d]) begin
        n = cyc - t0c[d];
        p = period[d];
        if (n < 16 * p) begin
          checkOutput($sformatf("busy d%0d n%0d", d, n), 32'(busy[d]), 32'd1);
          checkOutput($sformatf("early done d%0d n%0d", d, n), 32'(done[d]), 32'd0);
          if ((n % p) == p - 1) begin
            v = (n + 1) / p - 1;
            for (int k = 0; k < CH; k++) begin
              checkOutput($sformatf("stim d%0d v%0d ch%0d", d, v, k),
                          32'({c[d][k], b[d][k], a2[d][k], a1[d][k]}), 32'((v + k) % 16));
            end
          end
        end else begin
          checkOutput($sformatf("done timing d%0d", d), 32'(done[d]), 32'd1);
          checkOutput($sformatf("idle busy d%0d", d), 32'(busy[d]), 32'd0);
          checkOutput($sformatf("idle stim d%0d", d), stimOf(d), 32'd0);
          active[d] = 1'b0;
        end
      end
      if (done[d] && !prevDone[d]) begin
        if (sbq[d].size() == 0) begin
          checkOutput($sformatf("unexpected done d%0d", d), 32'd1, 32'd0);
        end else begin
          e = sbq[d].pop_front();
          checkOutput($sformatf("err d%0d", d), errOf(d), 32'(e.err));
          checkOutput($sformatf("mask d%0d", d), 32'(mask[d]), 32'(e.mask));
          checkOutput($sformatf("pass d%0d", d), 32'(pass[d]), 32'(e.pass));
        end
      end
      prevDone[d] = done[d];
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    setFlips(0, 0);
    setFlips(1, 0);
    repeat (3) @(negedge clk);
    checkAllZero(0, "reset d0");
    checkAllZero(1, "reset d1");
    rst = 1'b0;
    @(negedge clk);

    // Ideal loopback, then channel 2 stuck-at-1 (wrong only on vectors 13..15).
    applyStimulus(0);
    waitDone(0);
    setFlips(0, 0);
    flip[0][2] = 16'hE000;
    applyStimulus(0);
    waitDone(0);
    repeat (3) @(negedge clk);
    checkOutput("done held", 32'(done[0]), 32'd1);
    checkOutput("err held", errOf(0), 32'd3);

    for (int r = 0; r < 3; r++) begin
      setFlips(0, 2);
      applyStimulus(0);
      waitDone(0);
    end

    // A START during a run must not restart it; the monitor's timing checks catch a restart.
    setFlips(0, 2);
    flip[0][1][5] = 1'b1;
    applyStimulus(0);
    repeat (20) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    waitDone(0);

    // START while DONE: results clear and DONE drops right after the sampling edge.
    setFlips(0, 0);
    applyStimulus(0);
    checkOutput("restart done drop", 32'(done[0]), 32'd0);
    checkOutput("restart err clear", errOf(0), 32'd0);
    checkOutput("restart mask clear", 32'(mask[0]), 32'd0);
    checkOutput("restart busy", 32'(busy[0]), 32'd1);
    waitDone(0);

    // Reset during WAIT of vector 7 discards the partial run.
    setFlips(0, 1);
    applyStimulus(0);
    while (active[0] && (cyc - t0c[0]) < 7 * period[0] + 1) @(negedge clk);
    rst       = 1'b1;
    active[0] = 1'b0;
    sbq[0].delete();
    @(negedge clk);
    checkAllZero(0, "midrun reset");
    rst = 1'b0;
    setFlips(0, 0);
    applyStimulus(0);
    waitDone(0);

    // SETTLE=0 instance: ideal, all inverted (saturates at 3), then random faults.
    setFlips(1, 0);
    applyStimulus(1);
    waitDone(1);
    setFlips(1, 1);
    applyStimulus(1);
    waitDone(1);
    for (int r = 0; r < 3; r++) begin
      setFlips(1, 2);
      applyStimulus(1);
      waitDone(1);
    end

    repeat (4) @(negedge clk);
    checkOutput("scoreboard empty d0", 32'(sbq[0].size()), 32'd0);
    checkOutput("scoreboard empty d1", 32'(sbq[1].size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
